// File: rtl/nn_param_loader.sv
// ---------------------------------------------------------------------------
// nn_param_loader: streams weights/biases from one word stream into the 4-layer NN datapath.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module nn_param_loader #(
  parameter int DATA_WIDTH = 32,
  parameter int L1_NN = 30,
  parameter int L1_NW = 784,
  parameter int L2_NN = 30,
  parameter int L2_NW = 30,
  parameter int L3_NN = 10,
  parameter int L3_NW = 30,
  parameter int L4_NN = 10,
  parameter int L4_NW = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] load_data,
  input  logic                  load_valid,
  output logic                  load_ready,
  output logic [31:0]           config_layer_num,
  output logic [31:0]           config_neuron_num,
  output logic [31:0]           weightValue,
  output logic                  weightValid,
  output logic [31:0]           biasValue,
  output logic                  biasValid,
  output logic                  busy,
  output logic                  done
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int c_MAX_NW = max2(max2(L1_NW, L2_NW), max2(L3_NW, L4_NW));
  localparam int c_MAX_NN = max2(max2(L1_NN, L2_NN), max2(L3_NN, L4_NN));
  localparam int c_NW_W   = ($clog2(c_MAX_NW) < 1) ? 1 : $clog2(c_MAX_NW);
  localparam int c_NN_W   = ($clog2(c_MAX_NN) < 1) ? 1 : $clog2(c_MAX_NN);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_SETUP  = 3'd1,
    S_WEIGHT = 3'd2,
    S_BIAS   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [1:0]          r_layer;      // 0..3 encodes layer 1..4
  logic [c_NN_W-1:0]   r_neuron;
  logic [c_NW_W-1:0]   r_wcnt;
  logic [31:0]         r_cfg_layer;
  logic [31:0]         r_cfg_neuron;
  logic [31:0]         r_wval;
  logic [31:0]         r_bval;
  logic                r_wvalid;
  logic                r_bvalid;
  logic                r_busy;
  logic                r_done;

  logic                w_hs;
  logic [c_NW_W-1:0]   w_nw_last;
  logic [c_NN_W-1:0]   w_nn_last;
  logic                w_wlast;
  logic                w_nlast;
  logic                w_llast;

  assign load_ready = (r_state == S_WEIGHT) || (r_state == S_BIAS);
  assign w_hs       = load_valid && load_ready;

  always_comb begin
    w_nw_last = c_NW_W'(L1_NW - 1);
    w_nn_last = c_NN_W'(L1_NN - 1);
    case (r_layer)
      2'd1: begin
        w_nw_last = c_NW_W'(L2_NW - 1);
        w_nn_last = c_NN_W'(L2_NN - 1);
      end
      2'd2: begin
        w_nw_last = c_NW_W'(L3_NW - 1);
        w_nn_last = c_NN_W'(L3_NN - 1);
      end
      2'd3: begin
        w_nw_last = c_NW_W'(L4_NW - 1);
        w_nn_last = c_NN_W'(L4_NN - 1);
      end
      default: ;
    endcase
  end

  assign w_wlast = (r_wcnt == w_nw_last);
  assign w_nlast = (r_neuron == w_nn_last);
  assign w_llast = (r_layer == 2'd3);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next = S_SETUP;
      S_SETUP:  w_next = S_WEIGHT;
      S_WEIGHT: if (w_hs && w_wlast) w_next = S_BIAS;
      S_BIAS:   if (w_hs) w_next = (w_nlast && w_llast) ? S_DONE : S_SETUP;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
    if (abort) w_next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_layer      <= '0;
      r_neuron     <= '0;
      r_wcnt       <= '0;
      r_cfg_layer  <= 32'd1;
      r_cfg_neuron <= '0;
      r_wval       <= '0;
      r_bval       <= '0;
      r_wvalid     <= 1'b0;
      r_bvalid     <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_busy   <= (w_next != S_IDLE);
      r_done   <= (r_state == S_DONE) && !abort;
      r_wvalid <= 1'b0;
      r_bvalid <= 1'b0;
      if (abort) begin
        r_layer      <= '0;
        r_neuron     <= '0;
        r_wcnt       <= '0;
        r_cfg_layer  <= 32'd1;
        r_cfg_neuron <= '0;
      end else begin
        // config trails the counters so the bias strobe issued after BIAS keeps the old target
        r_cfg_layer  <= 32'(r_layer) + 32'd1;
        r_cfg_neuron <= 32'(r_neuron);
        if ((r_state == S_IDLE) && start) begin
          r_layer  <= '0;
          r_neuron <= '0;
          r_wcnt   <= '0;
        end
        if (w_hs && (r_state == S_WEIGHT)) begin
          r_wvalid <= 1'b1;
          r_wval   <= 32'(load_data);
          r_wcnt   <= w_wlast ? '0 : r_wcnt + c_NW_W'(1);
        end
        if (w_hs && (r_state == S_BIAS)) begin
          r_bvalid <= 1'b1;
          r_bval   <= 32'(load_data);
          r_wcnt   <= '0;
          if (w_nlast) begin
            r_neuron <= '0;
            r_layer  <= w_llast ? 2'd0 : r_layer + 2'd1;
          end else begin
            r_neuron <= r_neuron + c_NN_W'(1);
          end
        end
      end
    end
  end

  assign config_layer_num  = r_cfg_layer;
  assign config_neuron_num = r_cfg_neuron;
  assign weightValue       = r_wval;
  assign weightValid       = r_wvalid;
  assign biasValue         = r_bval;
  assign biasValid         = r_bvalid;
  assign busy              = r_busy;
  assign done              = r_done;

endmodule

`default_nettype wire
